// File: rtl/dff_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dff_write_arbiter
//  Description : Round-robin arbiter sharing the write port (E/D inputs) of a
//                DW-bit enabled register among N_REQ requesters. Produces a
//                registered one-hot grant that doubles as write acknowledge.
//                Optional burst locking is enabled by defining ARB_LOCK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module dff_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 4
`ifdef ARB_LOCK_EN
    ,
    parameter int MAX_BURST = 4
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] wdata,
`ifdef ARB_LOCK_EN
    input  logic [N_REQ-1:0]    lock,
`endif
    output logic [N_REQ-1:0]    gnt,
    output logic                reg_en,
    output logic [DW-1:0]       reg_d,
    output logic                busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_GRANT  = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    logic [1:0]       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [DW-1:0]    r_reg_d;
    logic [PW-1:0]    r_rr_ptr;

    logic [1:0]       w_state_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [DW-1:0]    w_reg_d_nxt;
    logic [PW-1:0]    w_rr_ptr_nxt;

    logic [N_REQ-1:0] w_eligible;
    logic             w_found;
    logic [PW-1:0]    w_win_idx;
    logic [DW-1:0]    w_wdata_arr [N_REQ];

`ifdef ARB_LOCK_EN
    logic [3:0]       r_burst_cnt;
    logic [3:0]       w_burst_cnt_nxt;
    logic             w_keep;
`endif

    // Slice the flat write-data bus into one word per requester
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_wdata_arr[gi] = wdata[gi*DW +: DW];
    end

    // The current holder is masked so others get a turn
    assign w_eligible = req & ~r_gnt;

    // Round-robin search starting just after the last winner
    always_comb begin : p_search
        logic [PW-1:0] v_pos;
        w_found   = 1'b0;
        w_win_idx = '0;
        v_pos     = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            v_pos = PW'((int'(r_rr_ptr) + off) % N_REQ);
            if (!w_found && w_eligible[v_pos]) begin
                w_found   = 1'b1;
                w_win_idx = v_pos;
            end
        end
    end

`ifdef ARB_LOCK_EN
    // Holder keeps the port while it asks for lock and the burst limit allows
    assign w_keep = ((r_gnt & req & lock) != '0) &&
                    (r_burst_cnt < 4'(MAX_BURST - 1));
`endif

    // Next grant, data, pointer and state
    always_comb begin
        w_state_nxt  = c_ST_IDLE;
        w_gnt_nxt    = '0;
        w_reg_d_nxt  = r_reg_d;
        w_rr_ptr_nxt = r_rr_ptr;
`ifdef ARB_LOCK_EN
        w_burst_cnt_nxt = 4'd0;
        if (w_keep) begin
            w_state_nxt     = c_ST_LOCKED;
            w_gnt_nxt       = r_gnt;
            w_reg_d_nxt     = w_wdata_arr[r_rr_ptr];
            w_burst_cnt_nxt = r_burst_cnt + 4'd1;
        end else
`endif
        if (w_found) begin
            w_state_nxt            = c_ST_GRANT;
            w_gnt_nxt[w_win_idx]   = 1'b1;
            w_reg_d_nxt            = w_wdata_arr[w_win_idx];
            w_rr_ptr_nxt           = w_win_idx;
        end
    end

    // Arbitration state; pointer starts at the top so requester 0 wins first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_gnt    <= '0;
            r_reg_d  <= '0;
            r_rr_ptr <= PW'(N_REQ - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_reg_d  <= w_reg_d_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

`ifdef ARB_LOCK_EN
    // Count consecutive locked writes of the current holder
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst_cnt <= 4'd0;
        end else begin
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end
`endif

    assign gnt    = r_gnt;
    assign reg_en = |r_gnt;
    assign reg_d  = r_reg_d;
    assign busy   = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
